// File: rtl/processor.sv
// Multi-cycle, non-pipelined 32-bit processor: FETCH -> EXEC -> (MEM) -> FETCH, with HALT.
// Single word-addressed memory port with a ready handshake; register file is not reset.
module processor #(
  parameter logic [31:0] START_PC_ADDRESS = 32'd0
) (
  input  logic        iClk,
  input  logic        nRst,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  output logic        oMemRead,
  output logic        oMemWrite
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 16;
  localparam int unsigned RW    = 4;
  localparam int unsigned OPW   = 5;
  localparam int unsigned CW    = 19;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;
  localparam logic [RW-1:0]  LINK_REG = 4'd15;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] ea_q;
  logic [XLEN-1:0] regs [NREGS];

  logic [OPW-1:0]  opcode;
  logic [RW-1:0]   ra, rb, rc;
  logic [1:0]      c2;
  logic [XLEN-1:0] c_sext;
  logic [XLEN-1:0] ra_val, rb_val, rc_val;
  logic [4:0]      shamt;
  logic [XLEN-1:0] ea;
  logic            is_ld, is_st;

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];
  assign c2     = ir[20:19];
  assign c_sext = {{(XLEN-CW){ir[CW-1]}}, ir[CW-1:0]};
  assign ra_val = regs[ra];
  assign rb_val = regs[rb];
  assign rc_val = regs[rc];
  assign shamt  = rc_val[4:0];
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);

  // r0 reads as zero only when used as a base register
  assign ea = ((rb == '0) ? '0 : rb_val) + c_sext;

  logic [2*XLEN-1:0] rot_dbl, rot_r, rot_l;
  logic [XLEN-1:0]   alu_res;
  logic              alu_wr;

  always_comb begin
    rot_dbl = {rb_val, rb_val};
    rot_r   = rot_dbl >> shamt;
    rot_l   = rot_dbl << shamt;
    alu_res = '0;
    alu_wr  = 1'b1;
    case (opcode)
      OP_LDI:  alu_res = ea;
      OP_ADD:  alu_res = rb_val + rc_val;
      OP_SUB:  alu_res = rb_val - rc_val;
      OP_AND:  alu_res = rb_val & rc_val;
      OP_OR:   alu_res = rb_val | rc_val;
      OP_ROR:  alu_res = rot_r[XLEN-1:0];
      OP_ROL:  alu_res = rot_l[2*XLEN-1:XLEN];
      OP_SHR:  alu_res = rb_val >> shamt;
      OP_SHRA: alu_res = XLEN'($signed(rb_val) >>> shamt);
      OP_SHL:  alu_res = rb_val << shamt;
      OP_ADDI: alu_res = rb_val + c_sext;
      OP_ANDI: alu_res = rb_val & c_sext;
      OP_ORI:  alu_res = rb_val | c_sext;
      OP_NEG:  alu_res = '0 - rb_val;
      OP_NOT:  alu_res = ~rb_val;
      default: alu_wr  = 1'b0;
    endcase
  end

  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (c2)
      2'b00: br_taken = (ra_val == '0);
      2'b01: br_taken = (ra_val != '0);
      2'b10: br_taken = !ra_val[XLEN-1] && (ra_val != '0);
      2'b11: br_taken = ra_val[XLEN-1];
      default: br_taken = 1'b0;
    endcase
  end

  // Strobes are decoded from the registered state and masked while reset is held
  assign oMemRead  = !nRst && ((state == FETCH) || ((state == MEM) && is_ld));
  assign oMemWrite = !nRst && (state == MEM) && is_st;
  assign oMemAddr  = (state == MEM) ? ea_q : pc;
  assign oMemData  = oMemWrite ? ra_val : '0;

  always_ff @(posedge iClk) begin
    if (nRst) begin
      pc    <= START_PC_ADDRESS;
      ir    <= '0;
      ea_q  <= '0;
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (iMemRdy) begin
            ir    <= iMemData;
            pc    <= pc + XLEN'(1);
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= FETCH;
          if (alu_wr) regs[ra] <= alu_res;
          case (opcode)
            OP_LD, OP_ST: begin
              ea_q  <= ea;
              state <= MEM;
            end
            OP_BR:   if (br_taken) pc <= pc + c_sext;
            OP_JR:   pc <= ra_val;
            // link is written first, so jal r15 jumps to the return address
            OP_JAL: begin
              regs[LINK_REG] <= pc;
              pc <= (ra == LINK_REG) ? pc : ra_val;
            end
            OP_HALT: state <= HALT;
            default: ;
          endcase
        end
        MEM: begin
          if (iMemRdy) begin
            if (is_ld) regs[ra] <= iMemData;
            state <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: table of small programs with expected stores,
// plus hand sequences for branching loops, jal, fetch wait states and reset mid-store.
module tb_processor;

  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5, OP_OR = 5'd6, OP_ROR = 5'd7, OP_ROL = 5'd8, OP_SHR = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10, OP_SHL = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI = 5'd14, OP_MUL = 5'd15, OP_NEG = 5'd17, OP_NOT = 5'd18;
  localparam logic [4:0] OP_BR = 5'd19, OP_JAL = 5'd21, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam int K_ALU = 0, K_BR = 1;
  localparam int NVEC = 26;

  logic        iClk = 1'b0;
  logic        nRst = 1'b1;
  logic        iMemRdy = 1'b1;
  logic [31:0] iMemData, oMemAddr, oMemData;
  logic        oMemRead, oMemWrite;
  logic [31:0] mem [256];

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int kind; logic [4:0] op; int a; int b; logic [31:0] ea; logic [31:0] ed; } vec_t;

  wr_t         obs_q[$], exp_q[$];
  logic [31:0] rd_q[$];
  int          both_strobes = 0;
  int          obs_idx, rd_start;
  int          n_checks = 0, n_fail = 0;
  bit          rand_wait = 1'b0;
  vec_t        vecs [NVEC];

  processor #(.START_PC_ADDRESS(32'd0)) dut (
    .iClk(iClk), .nRst(nRst), .oMemAddr(oMemAddr), .oMemData(oMemData), .iMemData(iMemData),
    .iMemRdy(iMemRdy), .oMemRead(oMemRead), .oMemWrite(oMemWrite));

  always #5 iClk = ~iClk;
  assign iMemData = mem[oMemAddr[7:0]];

  // Memory-side monitor: completed accesses as seen by a memory
  always @(posedge iClk) begin
    if (!nRst && iMemRdy && oMemWrite) obs_q.push_back('{oMemAddr, oMemData});
    if (!nRst && iMemRdy && oMemRead) rd_q.push_back(oMemAddr);
    if (oMemRead && oMemWrite) both_strobes++;
  end

  function automatic logic [31:0] enc_r(logic [4:0] op, int ra, int rb, int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction
  function automatic logic [31:0] enc_i(logic [4:0] op, int ra, int rb, int c);
    return {op, 4'(ra), 4'(rb), 19'(c)};
  endfunction
  function automatic logic [31:0] enc_br(int ra, int c2, int c);
    return {OP_BR, 4'(ra), 2'b00, 2'(c2), 19'(c)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input string name, input int k, input logic [31:0] exp);
    if (rd_start + k < rd_q.size()) chk(name, rd_q[rd_start + k], exp);
    else begin
      n_checks++; n_fail++;
      $display("FAIL %s: no read observed, required 0x%08h", name, exp);
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    if (rand_wait) iMemRdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = {OP_HALT, 27'd0};
  endtask

  task automatic do_reset();
    nRst = 1'b1;
    tick(); tick();
    obs_idx  = obs_q.size();
    rd_start = rd_q.size();
    nRst = 1'b0;
  endtask

  task automatic run_until(input int nwr, input int budget);
    int c = 0;
    while ((obs_q.size() - obs_idx < nwr) && (c < budget)) begin tick(); c++; end
    repeat (20) tick();
  endtask

  // Scoreboard drain, then confirm no stray writes and that the core has halted
  task automatic finish_check(input string name);
    wr_t e;
    int  nrd;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_idx < obs_q.size()) begin
        chk({name, "_waddr"}, obs_q[obs_idx].addr, e.addr);
        chk({name, "_wdata"}, obs_q[obs_idx].data, e.data);
      end else begin
        n_checks++; n_fail++;
        $display("FAIL %s_write: no write observed, required addr 0x%08h", name, e.addr);
      end
      obs_idx++;
    end
    chk({name, "_nwrites"}, 32'(obs_q.size()), 32'(obs_idx));
    nrd = rd_q.size();
    repeat (10) tick();
    chk({name, "_halted"}, 32'(rd_q.size()), 32'(nrd));
  endtask

  task automatic load_vec(input vec_t v);
    clear_mem();
    mem[0] = enc_i(OP_LDI, 0, 0, 0);
    mem[1] = enc_i(OP_ADDI, 1, 0, v.a);
    if (v.kind == K_ALU) begin
      mem[2] = enc_i(OP_ADDI, 2, 0, v.b);
      mem[3] = enc_i(OP_ADDI, 3, 0, 32'h55);
      if (v.op inside {OP_ADDI, OP_ANDI, OP_ORI}) mem[4] = enc_i(v.op, 3, 1, v.b);
      else if (v.op inside {OP_NEG, OP_NOT})      mem[4] = enc_r(v.op, 3, 1, 0);
      else                                        mem[4] = enc_r(v.op, 3, 1, 2);
      mem[5] = enc_i(OP_ST, 3, 0, 40);
    end else begin
      mem[2] = enc_br(1, v.op, 2);
      mem[3] = enc_i(OP_ST, 1, 0, 40);
      mem[5] = enc_i(OP_ST, 1, 0, 44);
    end
    exp_q.push_back('{v.ea, v.ed});
  endtask

  initial begin
    vecs[0]  = '{K_ALU, OP_ADD,  5,    7,  40, 32'd12};
    vecs[1]  = '{K_ALU, OP_SUB,  5,    7,  40, 32'hFFFFFFFE};
    vecs[2]  = '{K_ALU, OP_AND,  'hF0, 'h3C, 40, 32'h30};
    vecs[3]  = '{K_ALU, OP_OR,   'hF0, 'h3C, 40, 32'hFC};
    vecs[4]  = '{K_ALU, OP_ROR,  'hF0, 8,  40, 32'hF0000000};
    vecs[5]  = '{K_ALU, OP_ROR,  -16,  4,  40, 32'h0FFFFFFF};
    vecs[6]  = '{K_ALU, OP_ROL,  -16,  4,  40, 32'hFFFFFF0F};
    vecs[7]  = '{K_ALU, OP_SHR,  -16,  2,  40, 32'h3FFFFFFC};
    vecs[8]  = '{K_ALU, OP_SHRA, -16,  2,  40, 32'hFFFFFFFC};
    vecs[9]  = '{K_ALU, OP_SHL,  'hF0, 4,  40, 32'hF00};
    vecs[10] = '{K_ALU, OP_SHL,  1,    33, 40, 32'd2};
    vecs[11] = '{K_ALU, OP_ADDI, -1,   2,  40, 32'd1};
    vecs[12] = '{K_ALU, OP_ANDI, 'hF0, 'h3C, 40, 32'h30};
    vecs[13] = '{K_ALU, OP_ORI,  'hF0, 'h0F, 40, 32'hFF};
    vecs[14] = '{K_ALU, OP_NEG,  5,    0,  40, 32'hFFFFFFFB};
    vecs[15] = '{K_ALU, OP_NOT,  5,    0,  40, 32'hFFFFFFFA};
    vecs[16] = '{K_ALU, OP_MUL,  5,    7,  40, 32'h55};
    vecs[17] = '{K_ALU, OP_NOP,  5,    7,  40, 32'h55};
    vecs[18] = '{K_BR,  5'd0,    0,    0,  44, 32'd0};
    vecs[19] = '{K_BR,  5'd0,    5,    0,  40, 32'd5};
    vecs[20] = '{K_BR,  5'd1,    5,    0,  44, 32'd5};
    vecs[21] = '{K_BR,  5'd1,    0,    0,  40, 32'd0};
    vecs[22] = '{K_BR,  5'd2,    5,    0,  44, 32'd5};
    vecs[23] = '{K_BR,  5'd2,    0,    0,  40, 32'd0};
    vecs[24] = '{K_BR,  5'd2,    -3,   0,  40, 32'hFFFFFFFD};
    vecs[25] = '{K_BR,  5'd3,    -3,   0,  44, 32'hFFFFFFFD};

    // Reset state and first fetch right after reset release
    clear_mem();
    nRst = 1'b1;
    tick(); tick();
    chk("reset_read_strobe", {31'd0, oMemRead}, 32'd0);
    chk("reset_write_strobe", {31'd0, oMemWrite}, 32'd0);
    nRst = 1'b0;
    #1;
    chk("first_fetch_strobe", {31'd0, oMemRead}, 32'd1);
    chk("first_fetch_addr", oMemAddr, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      rand_wait = i[0];
      iMemRdy = 1'b1;
      load_vec(vecs[i]);
      do_reset();
      run_until(1, 400);
      finish_check($sformatf("vec%0d", i));
    end
    rand_wait = 1'b0;
    iMemRdy = 1'b1;

    // ld then st through absolute addressing
    clear_mem();
    mem[20] = 32'd10;
    mem[0] = enc_i(OP_LD, 1, 0, 20);
    mem[1] = enc_i(OP_ST, 1, 0, 30);
    exp_q.push_back('{32'd30, 32'd10});
    do_reset();
    run_until(1, 100);
    finish_check("ld_st");

    // Taken brzr to itself spins on address 1
    clear_mem();
    mem[21] = 32'd0;
    mem[0] = enc_i(OP_LD, 1, 0, 21);
    mem[1] = enc_br(1, 0, -1);
    mem[2] = enc_i(OP_ST, 1, 0, 40);
    do_reset();
    repeat (16) tick();
    chk_rd("brzr_rd0", 0, 32'd0);
    chk_rd("brzr_rd1", 1, 32'd21);
    chk_rd("brzr_rd2", 2, 32'd1);
    chk_rd("brzr_rd3", 3, 32'd1);
    chk_rd("brzr_rd4", 4, 32'd1);
    chk_rd("brzr_rd5", 5, 32'd1);
    chk("brzr_no_write", 32'(obs_q.size()), 32'(obs_idx));

    // Same loop falls through when the register is nonzero
    mem[21] = 32'd10;
    exp_q.push_back('{32'd40, 32'd10});
    do_reset();
    run_until(1, 100);
    chk_rd("brzr_nt_rd3", 3, 32'd2);
    finish_check("brzr_nt");

    // jal links the incremented PC into r15
    clear_mem();
    mem[0] = enc_i(OP_LDI, 5, 0, 3);
    mem[1] = enc_r(OP_JAL, 5, 0, 0);
    mem[2] = enc_i(OP_ST, 5, 0, 60);
    mem[3] = enc_i(OP_ST, 15, 0, 50);
    exp_q.push_back('{32'd50, 32'd2});
    do_reset();
    run_until(1, 100);
    chk_rd("jal_rd2", 2, 32'd3);
    finish_check("jal");

    // Fetch held by iMemRdy=0 for three cycles
    clear_mem();
    mem[0] = enc_i(OP_LDI, 0, 0, 0);
    mem[1] = enc_i(OP_ADDI, 1, 0, 9);
    mem[2] = enc_i(OP_ST, 1, 0, 40);
    exp_q.push_back('{32'd40, 32'd9});
    do_reset();
    iMemRdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wait%0d_read", k), {31'd0, oMemRead}, 32'd1);
      chk($sformatf("wait%0d_addr", k), oMemAddr, 32'd0);
    end
    chk("wait_no_fetch", 32'(rd_q.size()), 32'(rd_start));
    iMemRdy = 1'b1;
    run_until(1, 100);
    finish_check("wait");

    // Reset while a store is stalled in MEM aborts it
    clear_mem();
    mem[0] = enc_i(OP_LDI, 2, 0, 32'h77);
    mem[1] = enc_i(OP_ST, 2, 0, 40);
    do_reset();
    begin
      int c = 0;
      while (!oMemWrite && c < 50) begin tick(); c++; end
    end
    iMemRdy = 1'b0;
    chk("rst_st_write", {31'd0, oMemWrite}, 32'd1);
    chk("rst_st_data", oMemData, 32'h77);
    tick();
    chk("rst_st_addr", oMemAddr, 32'd40);
    nRst = 1'b1;
    #1;
    chk("rst_st_masked", {31'd0, oMemWrite}, 32'd0);
    tick();
    nRst = 1'b0;
    iMemRdy = 1'b1;
    #1;
    chk("rst_st_no_write", 32'(obs_q.size()), 32'(obs_idx));
    chk("rst_st_refetch", oMemAddr, 32'd0);
    rd_start = rd_q.size();
    exp_q.push_back('{32'd40, 32'h77});
    run_until(1, 100);
    chk_rd("rst_st_rd0", 0, 32'd0);
    finish_check("rst_st");

    chk("strobes_exclusive", 32'(both_strobes), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have parameter START_PC_ADDRESS, default 32'd0: PC value loaded on reset.
REQ-002 SHALL have port iClk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRst, input, 1 bit: reset, synchronous and active-high (processor is in reset on any rising iClk edge where nRst=1).
REQ-004 SHALL have port oMemAddr, output, 32 bits: word address for fetch, load and store.
REQ-005 SHALL have port oMemData, output, 32 bits: store data.
REQ-006 SHALL have port iMemData, input, 32 bits: instruction or load data.
REQ-007 SHALL have port iMemRdy, input, 1 bit: memory ready; 1 completes the current read or write this cycle.
REQ-008 SHALL have port oMemRead, output, 1 bit: read strobe.
REQ-009 SHALL have port oMemWrite, output, 1 bit: write strobe.

Function
REQ-010 SHALL be a multi-cycle, non-pipelined FSM with states FETCH, EXEC, MEM, HALT; each instruction completes before the next fetch.
REQ-011 SHALL contain 16 x 32-bit registers r0-r15, a 32-bit PC and a 32-bit IR; register file is not cleared on reset.
REQ-012 SHALL decode opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0] sign-extended to 32 bits; for branches C2=IR[20:19].
REQ-013 SHALL in FETCH drive oMemRead=1, oMemAddr=PC; on an edge with iMemRdy=1 latch IR<=iMemData, PC<=PC+1, go to EXEC; while iMemRdy=0 remain in FETCH.
REQ-014 SHALL support R-type opcodes add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011: Ra<=Rb op Rc, written in EXEC, then FETCH (2 cycles total with zero-wait memory).
REQ-015 SHALL support addi 01100, andi 01101, ori 01110: Ra<=Rb op C; neg 10001 and not 10010: Ra<=op Rb; shift amount = low 5 bits of Rc; arithmetic wraps modulo 2^32.
REQ-016 SHALL support ld 00000: EA=(Rb==0 ? 0 : reg[Rb])+C; ldi 00001: Ra<=EA with no memory access; st 00010: mem[EA]<=reg[Ra]; the Rb==0 rule gives absolute addressing.
REQ-017 SHALL for ld/st go EXEC->MEM; in MEM drive oMemAddr=EA with oMemRead=1 (ld) or oMemWrite=1 and oMemData=reg[Ra] (st); complete on the edge with iMemRdy=1 (ld writes Ra), then FETCH.
REQ-018 SHALL support br 10011 with C2: 00 zero, 01 nonzero, 10 positive (bit31=0 and nonzero), 11 negative (bit31=1), tested on reg[Ra]; if taken PC<=PC+C, where PC has already been incremented.
REQ-019 SHALL support jr 10100: PC<=reg[Ra]; jal 10101: r15<=PC (incremented), then PC<=reg[Ra], r15 written before PC is read.
REQ-020 SHALL treat nop 11010 and unimplemented opcodes (div, mul, in, out, mfhi, mflo, others) as no-operation; halt 11011 enters HALT, which only reset leaves.
REQ-021 SHALL drive oMemRead=oMemWrite=0 in EXEC and HALT, never assert both strobes together, and drive oMemData=0 except during a store.
REQ-022 SHALL treat writes to r0 as normal register writes; r0 is special only as a base register (REQ-016).

Reset
REQ-023 SHALL, on an edge with nRst=1, set PC<=START_PC_ADDRESS, IR<=0, state<=FETCH, oMemRead=oMemWrite=0; this applies from any state, including mid-MEM, and aborts any pending access.
REQ-024 SHALL start the first fetch at START_PC_ADDRESS in the first cycle after nRst falls to 0.

Verification
REQ-025 SHALL pass: mem[20]=10, program "ld r1,20(r0); st r1,30(r0)" -> write addr 30, data 10.
REQ-026 SHALL pass: mem[21]=0, "ld r1,21(r0); brzr r1,-1" -> branch taken, re-fetches the brzr address repeatedly; with r1=10, not taken, next sequential fetch occurs.
REQ-027 SHALL pass: "addi r2,r0,5; addi r3,r0,7; add r4,r2,r3; st r4,40(r0)" -> write addr 40, data 12; "sub" variant gives 0xFFFFFFFE.
REQ-028 SHALL pass: "ldi r5,3; jal r5" at addresses 0-1 -> next fetch at 3, r15=2 (checked via st r15).
REQ-029 SHALL pass: iMemRdy held 0 for 3 cycles during fetch -> FETCH holds and the address is stable; an instruction completes after iMemRdy=1.
REQ-030 SHALL pass: nRst=1 asserted while in MEM of a store -> no write occurs and the fetch restarts at START_PC_ADDRESS.
